// File: rtl/opcode_decoder.sv
// Fetch-side opcode decoder: accepts an opcode byte plus up to two operand bytes,
// decodes the 6502-style addressing mode and hands the instruction to execute.
module opcode_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        exec_done,
  output logic        fetch_req,
  output logic [7:0]  instruction,
  output logic [15:0] operand,
  output logic        immediate,
  output logic        absolute,
  output logic        zpg_absolute,
  output logic        implied,
  output logic        accumulator,
  output logic        abs_indexed_x,
  output logic        abs_indexed_y,
  output logic        zpg_indexed_x,
  output logic        zpg_indexed_y,
  output logic        indirect,
  output logic        indirect_x,
  output logic        indirect_y,
  output logic        relative,
  output logic        newinst
);

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_LO,
    FETCH_HI,
    ISSUE,
    WAIT_EXEC
  } state_t;

  localparam int M_REL  = 0;
  localparam int M_INDY = 1;
  localparam int M_INDX = 2;
  localparam int M_IND  = 3;
  localparam int M_ZPGY = 4;
  localparam int M_ZPGX = 5;
  localparam int M_ABSY = 6;
  localparam int M_ABSX = 7;
  localparam int M_ACC  = 8;
  localparam int M_IMP  = 9;
  localparam int M_ZPG  = 10;
  localparam int M_ABS  = 11;
  localparam int M_IMM  = 12;

  state_t      state, next_state;
  logic [12:0] dec_modes;
  logic [12:0] mode_q;
  logic [2:0]  op_a, op_b;
  logic [1:0]  op_c;

  // Operand bytes that follow an opcode with the given addressing mode.
  function automatic logic [1:0] byte_count(input logic [12:0] m);
    if (m[M_ABS] | m[M_ABSX] | m[M_ABSY] | m[M_IND])
      return 2'd2;
    if (m[M_IMM] | m[M_ZPG] | m[M_ZPGX] | m[M_ZPGY] | m[M_INDX] | m[M_INDY] | m[M_REL])
      return 2'd1;
    return 2'd0;
  endfunction

  assign op_a = data_in[7:5];
  assign op_b = data_in[4:2];
  assign op_c = data_in[1:0];

  // Opcode grid decode on the incoming byte; it is only captured in FETCH_OP.
  always_comb begin
    dec_modes = '0;
    case (op_c)
      2'b01: begin
        case (op_b)
          3'd0: dec_modes[M_INDX] = 1'b1;
          3'd1: dec_modes[M_ZPG]  = 1'b1;
          3'd2: dec_modes[M_IMM]  = 1'b1;
          3'd3: dec_modes[M_ABS]  = 1'b1;
          3'd4: dec_modes[M_INDY] = 1'b1;
          3'd5: dec_modes[M_ZPGX] = 1'b1;
          3'd6: dec_modes[M_ABSY] = 1'b1;
          3'd7: dec_modes[M_ABSX] = 1'b1;
          default: ;
        endcase
      end
      2'b10: begin
        case (op_b)
          3'd0: if (op_a == 3'd5) dec_modes[M_IMM] = 1'b1;
          3'd1: dec_modes[M_ZPG] = 1'b1;
          3'd2: begin
            if (op_a < 3'd4) dec_modes[M_ACC] = 1'b1;
            else             dec_modes[M_IMP] = 1'b1;
          end
          3'd3: dec_modes[M_ABS] = 1'b1;
          3'd5: begin
            if (op_a == 3'd4 || op_a == 3'd5) dec_modes[M_ZPGY] = 1'b1;
            else                              dec_modes[M_ZPGX] = 1'b1;
          end
          3'd6: if (op_a == 3'd4 || op_a == 3'd5) dec_modes[M_IMP] = 1'b1;
          3'd7: begin
            if (op_a == 3'd5)      dec_modes[M_ABSY] = 1'b1;
            else if (op_a != 3'd4) dec_modes[M_ABSX] = 1'b1;
          end
          default: ;
        endcase
      end
      2'b00: begin
        case (op_b)
          3'd0: begin
            case (op_a)
              3'd0, 3'd2, 3'd3: dec_modes[M_IMP] = 1'b1;
              3'd1:             dec_modes[M_ABS] = 1'b1;
              3'd5, 3'd6, 3'd7: dec_modes[M_IMM] = 1'b1;
              default: ;
            endcase
          end
          3'd1: if (op_a != 3'd0 && op_a != 3'd2 && op_a != 3'd3) dec_modes[M_ZPG] = 1'b1;
          3'd2, 3'd6: dec_modes[M_IMP] = 1'b1;
          3'd3: begin
            if (op_a == 3'd3)      dec_modes[M_IND] = 1'b1;
            else if (op_a != 3'd0) dec_modes[M_ABS] = 1'b1;
          end
          3'd4: dec_modes[M_REL] = 1'b1;
          3'd5: if (op_a == 3'd4 || op_a == 3'd5) dec_modes[M_ZPGX] = 1'b1;
          3'd7: if (op_a == 3'd5) dec_modes[M_ABSX] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH_OP;
    else        state <= next_state;
  end

  // FETCH_LO consults the latched modes, FETCH_OP the byte being accepted.
  always_comb begin
    next_state = state;
    fetch_req  = 1'b0;
    newinst    = 1'b0;
    case (state)
      FETCH_OP: begin
        fetch_req = 1'b1;
        if (data_valid)
          next_state = (byte_count(dec_modes) == 2'd0) ? ISSUE : FETCH_LO;
      end
      FETCH_LO: begin
        fetch_req = 1'b1;
        if (data_valid)
          next_state = (byte_count(mode_q) == 2'd2) ? FETCH_HI : ISSUE;
      end
      FETCH_HI: begin
        fetch_req = 1'b1;
        if (data_valid) next_state = ISSUE;
      end
      ISSUE: begin
        newinst    = 1'b1;
        next_state = WAIT_EXEC;
      end
      WAIT_EXEC: begin
        if (exec_done) next_state = FETCH_OP;
      end
      default: next_state = FETCH_OP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= 8'h00;
      operand     <= 16'h0000;
      mode_q      <= '0;
    end else if (data_valid) begin
      case (state)
        FETCH_OP: begin
          instruction <= data_in;
          mode_q      <= dec_modes;
          operand     <= 16'h0000;
        end
        FETCH_LO: operand[7:0]  <= data_in;
        FETCH_HI: operand[15:8] <= data_in;
        default: ;
      endcase
    end
  end

  assign immediate     = mode_q[M_IMM];
  assign absolute      = mode_q[M_ABS];
  assign zpg_absolute  = mode_q[M_ZPG];
  assign implied       = mode_q[M_IMP];
  assign accumulator   = mode_q[M_ACC];
  assign abs_indexed_x = mode_q[M_ABSX];
  assign abs_indexed_y = mode_q[M_ABSY];
  assign zpg_indexed_x = mode_q[M_ZPGX];
  assign zpg_indexed_y = mode_q[M_ZPGY];
  assign indirect      = mode_q[M_IND];
  assign indirect_x    = mode_q[M_INDX];
  assign indirect_y    = mode_q[M_INDY];
  assign relative      = mode_q[M_REL];

endmodule

// File: doc/opcode_decoder.md
OPCODE_DECODER -- requirements
Module: opcode_decoder

Interface
REQ-001 SHALL have ports, in this order: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 SHALL have input data_in 8 (fetched byte) and input data_valid 1 (data_in valid this cycle).
REQ-003 SHALL have input exec_done 1, a one-cycle pulse from the execute stage meaning the instruction has finished.
REQ-004 SHALL have output fetch_req 1, meaning the decoder wants a byte.
REQ-005 SHALL have output instruction 8 (latched opcode) and output operand 16 (low byte in [7:0], high byte in [15:8]).
REQ-006 SHALL have these 1-bit outputs, all registered: immediate, absolute, zpg_absolute, implied, accumulator, abs_indexed_x, abs_indexed_y, zpg_indexed_x, zpg_indexed_y, indirect, indirect_x, indirect_y, relative.
REQ-007 SHALL have output newinst 1, a one-cycle pulse meaning the instruction and operand are complete.

Function
REQ-008 SHALL implement states FETCH_OP, FETCH_LO, FETCH_HI, ISSUE, WAIT_EXEC.
REQ-009 SHALL drive fetch_req=1 exactly in FETCH_OP, FETCH_LO and FETCH_HI, and SHALL ignore data_valid in all other states.
REQ-010 In FETCH_OP with data_valid=1, SHALL register instruction=data_in, the decoded mode flags and operand=0000 on the same edge.
- In this REQ, "a" means opcode[7:5], "b" means [4:2] and "c" means [1:0].
- Next state: FETCH_LO if the byte count is 1 or 2; ISSUE if it is 0.
REQ-011 Byte count SHALL be:
- 2 for absolute, abs_indexed_x, abs_indexed_y and indirect;
- 1 for immediate, zpg_absolute, zpg_indexed_x, zpg_indexed_y, indirect_x, indirect_y and relative;
- 0 for all other opcodes.
REQ-012 Decode for c=01 SHALL map b 0..7 to: indirect_x, zpg_absolute, immediate, absolute, indirect_y, zpg_indexed_x, abs_indexed_y, abs_indexed_x.
REQ-013 Decode for c=10 SHALL be:
- b0: immediate only for A2;
- b1: zpg_absolute;
- b2: accumulator if a<4, else implied;
- b3: absolute;
- b5: zpg_indexed_y if a is 4 or 5, else zpg_indexed_x;
- b6: implied only for 9A and BA;
- b7: abs_indexed_y if a=5, abs_indexed_x if a≠4.
REQ-014 Decode for c=00 SHALL be:
- 00, 40, 60: implied; 20: absolute; A0, C0, E0: immediate;
- b1: zpg_absolute when a∈{1,4,5,6,7};
- b2 and b6: implied;
- b3: indirect for 6C, absolute for a≠0;
- b4: relative;
- b5: zpg_indexed_x when a∈{4,5};
- b7: abs_indexed_x only for BC.
REQ-015 Every opcode not covered by REQ-012..014, and every opcode with c=11, SHALL leave all mode flags 0. At most one mode flag SHALL be 1 at any time.
REQ-016 In FETCH_LO with data_valid=1, SHALL load operand[7:0]=data_in. Next state: FETCH_HI if the byte count is 2, else ISSUE.
REQ-017 In FETCH_HI with data_valid=1, SHALL load operand[15:8]=data_in. Next state: ISSUE.
REQ-018 A FETCH state SHALL hold indefinitely while data_valid=0, with no timeout.
REQ-019 ISSUE SHALL last exactly one cycle with newinst=1, then go to WAIT_EXEC.
- Latency: newinst is high in the cycle after the last byte is accepted.
REQ-020 WAIT_EXEC SHALL go to FETCH_OP on the cycle after exec_done=1. exec_done in any other state SHALL be ignored.
REQ-021 instruction, operand and the mode flags SHALL hold stable from ISSUE until the next opcode is accepted.

Reset
REQ-022 While rst_n=0, asynchronously:
- state=FETCH_OP; fetch_req=1;
- instruction=00, operand=0000;
- all mode flags=0; newinst=0.
REQ-023 Reset asserted mid-fetch or in ISSUE SHALL discard partial bytes, and newinst SHALL NOT fire.
REQ-024 After rst_n deasserts, the first data_valid byte SHALL be treated as an opcode.

Verification
REQ-025 Bench SHALL cover these directed scenarios:
- A9 then 42: immediate=1, operand=0042, one newinst pulse the cycle after 42 is accepted.
- AD,34,12 with a 3-cycle data_valid gap before 12: absolute=1, operand=1234, fetch_req held high through the gap.
- 0A: accumulator=1, newinst the cycle after the opcode; data_valid=1 during WAIT_EXEC is ignored until exec_done.
- 6C,00,02 → indirect; B6,10 → zpg_indexed_y; BE,00,30 → abs_indexed_y; 02 → no mode flag, newinst after 1 cycle.
- Reset pulsed after AD,34 is accepted: all outputs return to reset values, no newinst; next byte EA decodes as implied.
- Exhaustive sweep 00..FF: flags are one-hot-or-zero, and the byte count matches the REQ-011 golden table.
